// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART driver's transmit interface: a write strobe fills it, a
// valid/ready handshake drains it, and fill level plus a sticky overflow flag are reported.
module uart_tx_fifo #(
    parameter int P_DATA_WIDTH = 8,
    parameter int P_ADDR_WIDTH = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [P_DATA_WIDTH-1:0] i_wr_data,
    input  logic                    i_wr_en,
    input  logic                    i_flush,
    output logic                    o_full,
    output logic                    o_empty,
    output logic [P_ADDR_WIDTH:0]   o_count,
    output logic                    o_overflow,
    output logic [P_DATA_WIDTH-1:0] o_tx_data,
    output logic                    o_tx_valid,
    input  logic                    i_tx_ready
);

    localparam int DEPTH = 1 << P_ADDR_WIDTH;
    localparam logic [P_ADDR_WIDTH:0] FULL_COUNT = (P_ADDR_WIDTH + 1)'(DEPTH);

    logic [P_DATA_WIDTH-1:0] mem [DEPTH];
    logic [P_ADDR_WIDTH-1:0] wr_ptr;
    logic [P_ADDR_WIDTH-1:0] rd_ptr;
    logic [P_ADDR_WIDTH:0]   count;
    logic                    overflow;

    logic full;
    logic empty;
    logic wr_accept;
    logic wr_reject;
    logic pop;

    // Handshake: a byte moves to the driver on every rising edge where o_tx_valid and
    // i_tx_ready are both high. o_tx_valid depends only on stored state, so it never
    // waits for i_tx_ready, and the head byte cannot change or vanish until it is
    // popped (flush and reset excepted).
    assign full      = (count == FULL_COUNT);
    assign empty     = (count == '0);
    assign pop       = !empty && i_tx_ready;
    assign wr_accept = i_wr_en && !full;
    // Fullness is judged before any same-cycle pop, so a write into a full FIFO is
    // rejected even while a byte is leaving.
    assign wr_reject = i_wr_en && full;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_accept && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !wr_accept) begin
                count <= count - 1'b1;
            end
            if (wr_reject) begin
                overflow <= 1'b1;
            end
        end
    end

    // Storage needs no reset; stale words are never visible because valid tracks count.
    always_ff @(posedge i_clk) begin
        if (wr_accept && !i_rst && !i_flush) begin
            mem[wr_ptr] <= i_wr_data;
        end
    end

    assign o_full     = full;
    assign o_empty    = empty;
    assign o_count    = count;
    assign o_overflow = overflow;
    assign o_tx_valid = !empty;
    assign o_tx_data  = mem[rd_ptr];

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: reset, latency, full/overflow, write+pop at full,
// pointer wrap-around streaming, flush priority and reset mid-drain.
module tb_uart_tx_fifo;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          rst;
    logic [DW-1:0] wr_data;
    logic          wr_en;
    logic          flush;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          overflow;
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic          tx_ready;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] exp_q[$];

    uart_tx_fifo #(
        .P_DATA_WIDTH(DW),
        .P_ADDR_WIDTH(AW)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_wr_data (wr_data),
        .i_wr_en   (wr_en),
        .i_flush   (flush),
        .o_full    (full),
        .o_empty   (empty),
        .o_count   (count),
        .o_overflow(overflow),
        .o_tx_data (tx_data),
        .o_tx_valid(tx_valid),
        .i_tx_ready(tx_ready)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; inputs are driven and outputs sampled 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic write_byte(input logic [DW-1:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_empty"}, 32'(empty), 32'd1);
        check({tag, "_full"}, 32'(full), 32'd0);
        check({tag, "_count"}, 32'(count), 32'd0);
        check({tag, "_overflow"}, 32'(overflow), 32'd0);
        check({tag, "_valid"}, 32'(tx_valid), 32'd0);
    endtask

    initial begin
        int sent;
        int recv;
        int cyc;
        logic [DW-1:0] exp_b;

        rst      = 1'b1;
        wr_data  = '0;
        wr_en    = 1'b0;
        flush    = 1'b0;
        tx_ready = 1'b0;
        #1;
        step();
        step();
        rst = 1'b0;
        check_reset_state("reset");

        // Single byte: visible one cycle after the write, held while not ready.
        write_byte(8'h41);
        check("t1_valid", 32'(tx_valid), 32'd1);
        check("t1_data", 32'(tx_data), 32'h41);
        check("t1_count", 32'(count), 32'd1);
        check("t1_empty", 32'(empty), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("t1_hold_data", 32'(tx_data), 32'h41);
            check("t1_hold_valid", 32'(tx_valid), 32'd1);
        end
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
        check("t1_pop_empty", 32'(empty), 32'd1);
        check("t1_pop_count", 32'(count), 32'd0);
        check("t1_pop_valid", 32'(tx_valid), 32'd0);

        // Fill to capacity, overflow on the 17th write, then drain in order.
        for (int i = 0; i < DEPTH; i++) begin
            write_byte(8'(i));
        end
        check("t2_full", 32'(full), 32'd1);
        check("t2_count", 32'(count), 32'd16);
        check("t2_ovf_before", 32'(overflow), 32'd0);
        write_byte(8'hFF);
        check("t2_overflow", 32'(overflow), 32'd1);
        check("t2_count_after_ovf", 32'(count), 32'd16);
        tx_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            check("t2_drain_valid", 32'(tx_valid), 32'd1);
            check("t2_drain_data", 32'(tx_data), 32'(i));
            step();
        end
        tx_ready = 1'b0;
        check("t2_drained_empty", 32'(empty), 32'd1);
        check("t2_drained_valid", 32'(tx_valid), 32'd0);
        check("t2_ovf_sticky", 32'(overflow), 32'd1);

        // Write+pop while full: write rejected, pop proceeds.
        do_flush();
        check("t3_flush_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            write_byte(8'(8'h10 + i));
        end
        wr_en    = 1'b1;
        wr_data  = 8'hAA;
        tx_ready = 1'b1;
        step();
        check("t3_full_wp_ovf", 32'(overflow), 32'd1);
        check("t3_full_wp_count", 32'(count), 32'd15);
        check("t3_full_wp_head", 32'(tx_data), 32'h11);
        wr_data = 8'hBB;
        step();
        wr_en    = 1'b0;
        tx_ready = 1'b0;
        check("t3_wp_count", 32'(count), 32'd15);
        check("t3_wp_head", 32'(tx_data), 32'h12);
        check("t3_wp_full", 32'(full), 32'd0);

        // Streaming across pointer wrap with ready asserted one cycle in three.
        do_flush();
        exp_q.delete();
        sent = 0;
        recv = 0;
        cyc  = 0;
        while (recv < 40 && cyc < 1000) begin
            tx_ready = (cyc % 3 == 0);
            wr_en    = (sent < 40) && !full;
            wr_data  = 8'($urandom_range(0, 255));
            if (tx_valid && tx_ready) begin
                exp_b = exp_q.pop_front();
                check("t4_stream_data", 32'(tx_data), 32'(exp_b));
                recv++;
            end
            if (wr_en) begin
                exp_q.push_back(wr_data);
                sent++;
            end
            step();
            cyc++;
        end
        wr_en    = 1'b0;
        tx_ready = 1'b0;
        check("t4_stream_done", 32'(recv), 32'd40);
        check("t4_no_overflow", 32'(overflow), 32'd0);
        check("t4_end_empty", 32'(empty), 32'd1);

        // Flush beats a same-cycle write and pop.
        for (int i = 0; i < 5; i++) begin
            write_byte(8'(8'h30 + i));
        end
        check("t5_loaded_count", 32'(count), 32'd5);
        flush    = 1'b1;
        wr_en    = 1'b1;
        wr_data  = 8'h77;
        tx_ready = 1'b1;
        step();
        flush    = 1'b0;
        wr_en    = 1'b0;
        tx_ready = 1'b0;
        check_reset_state("t5_flush");
        write_byte(8'h55);
        check("t5_new_head", 32'(tx_data), 32'h55);
        check("t5_new_count", 32'(count), 32'd1);

        // Reset mid-drain after overflow.
        for (int i = 0; i < DEPTH - 1; i++) begin
            write_byte(8'(8'h60 + i));
        end
        write_byte(8'hEE);
        check("t6_ovf_set", 32'(overflow), 32'd1);
        tx_ready = 1'b1;
        step();
        check("t6_mid_drain_count", 32'(count), 32'd15);
        rst   = 1'b1;
        wr_en = 1'b1;
        step();
        rst      = 1'b0;
        wr_en    = 1'b0;
        tx_ready = 1'b0;
        check_reset_state("t6_rst");

        // Report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
